d_mem: RTL and testbench

Data memory stage for the MIPS datapath, fed by the ULA result as address and by register file read data as store data. It returns load data to the write-back mux. It serves byte, halfword and word loads and stores, each with a fixed, parameterised access latency, behind a request/ready handshake. While an access is in flight it raises `busy`, which the control unit uses to stall the PC. Memory is little-endian and word-organised, and misaligned accesses are detected and rejected.

---
 rtl/d_mem.sv | 197 +++++++++++++++++++
 tb/tb_d_mem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/d_mem.sv
// d_mem: data memory stage of the MIPS datapath.
// Serves byte/halfword/word loads and stores with a fixed LATENCY behind a
// request/ready handshake. Memory is little-endian and word organised, and
// misaligned accesses are rejected without touching memory or rdata.
//
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-high reset (also clears the memory)
//   req         - access request, accepted in IDLE or DONE
//   we          - 1 = store, 0 = load
//   size        - 00 byte, 01 halfword, 10/11 word
//   unsigned_ld - 1 = zero-extend narrow loads, 0 = sign-extend
//   addr        - byte address (upper bits beyond the array wrap)
//   wdata       - store data, low byte/half used for narrow stores
//   rdata       - registered load result
//   ready       - one-cycle completion pulse
//   busy        - high while the access is waiting
//   misaligned  - high together with ready when the access was rejected
module d_mem #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        misaligned
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_mem [DEPTH];

   logic [AW-1:0]   r_idx;
   logic [1:0]      r_off;
   logic            r_we;
   logic [1:0]      r_size;
   logic            r_uns;
   logic [31:0]     r_wdata;

   logic [31:0]     r_rdata;
   logic            r_ready;
   logic            r_busy;
   logic            r_mis;

   logic            w_accept;
   logic            w_misal;
   logic            w_next_mis;
   logic            w_do_access;
   logic [3:0]      w_be;
   logic [31:0]     w_wlanes;
   logic [31:0]     w_word;
   logic [31:0]     w_shift;
   logic [15:0]     w_half;
   logic [31:0]     w_load_data;
   logic            w_unused_addr;

   // Address bits above the array are deliberately ignored (wrap-around).
   assign w_unused_addr = ^addr[31:AW+2];

   // Alignment check on the incoming request; size 11 behaves as word.
   assign w_misal = ((size == 2'b01) && addr[0]) ||
                    (size[1] && (addr[1:0] != 2'b00));

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_do_access  = 1'b0;
      w_next_mis   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_next_state = S_IDLE;
            if (req) begin
               w_accept     = 1'b1;
               w_next_state = w_misal ? S_DONE : S_WAIT;
               w_next_mis   = w_misal;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_do_access  = 1'b1;
               w_next_state = S_DONE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Byte-lane enables and lane-replicated store data.
   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = r_wdata;
      case (r_size)
         2'b00: begin
            w_be     = 4'b0001 << r_off;
            w_wlanes = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = r_off[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{r_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = r_wdata;
         end
      endcase
   end

   // Load lane selection and extension.
   always_comb begin
      w_word      = r_mem[r_idx];
      w_shift     = w_word >> {r_off, 3'b000};
      w_half      = r_off[1] ? w_word[31:16] : w_word[15:0];
      w_load_data = w_word;
      case (r_size)
         2'b00:   w_load_data = r_uns ? {24'd0, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_load_data = r_uns ? {16'd0, w_half}
                                      : {{16{w_half[15]}}, w_half};
         default: w_load_data = w_word;
      endcase
   end

   // State, capture, counter, memory and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_off   <= '0;
         r_we    <= 1'b0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_mis   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == S_WAIT);
         r_ready <= (w_next_state == S_DONE);
         r_mis   <= w_next_mis;

         if (w_accept) begin
            r_idx   <= addr[AW+1:2];
            r_off   <= addr[1:0];
            r_we    <= we;
            r_size  <= size;
            r_uns   <= unsigned_ld;
            r_wdata <= wdata;
            r_cnt   <= CW'(LATENCY - 1);
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end

         if (w_do_access) begin
            if (r_we) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_be[b]) begin
                     r_mem[r_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                  end
               end
            end else begin
               r_rdata <= w_load_data;
            end
         end
      end
   end

   assign rdata      = r_rdata;
   assign ready      = r_ready;
   assign busy       = r_busy;
   assign misaligned = r_mis;

endmodule

// File: tb/tb_d_mem.sv
// Directed bench for d_mem (DEPTH=256, LATENCY=2): a vector table of single
// accesses plus hand-written reset and back-to-back sequences.
module tb_d_mem;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned LATENCY = 2;

   logic        clock;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        misaligned;

   int total;
   int bad;

   d_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .we          (we),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .ready       (ready),
      .busy        (busy),
      .misaligned  (misaligned)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request (starting just after an edge) and follow it to completion.
   task automatic run_vec(input vec_t v);
      int n;
      int bcnt;
      int exp_lat;
      int exp_busy;
      we          = v.we;
      size        = v.size;
      unsigned_ld = v.uns;
      addr        = v.addr;
      wdata       = v.wdata;
      req         = 1'b1;
      @(posedge clock);
      #1 req = 1'b0;
      n    = 0;
      bcnt = 0;
      while (!ready && n < 20) begin
         if (busy) bcnt++;
         @(posedge clock);
         #1;
         n++;
      end
      exp_lat  = v.exp_mis ? 0 : LATENCY;
      exp_busy = v.exp_mis ? 0 : LATENCY;
      check({v.name, " ready seen"}, 32'(ready), 32'd1);
      check({v.name, " latency"}, 32'(n), 32'(exp_lat));
      check({v.name, " busy cycles"}, 32'(bcnt), 32'(exp_busy));
      check({v.name, " rdata"}, rdata, v.exp_rdata);
      check({v.name, " misaligned"}, 32'(misaligned), 32'(v.exp_mis));
      @(posedge clock);
      #1;
      check({v.name, " ready drop"}, {30'd0, ready, misaligned}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      vec_t v;
      total       = 0;
      bad         = 0;
      req         = 1'b0;
      we          = 1'b0;
      size        = 2'b00;
      unsigned_ld = 1'b0;
      addr        = '0;
      wdata       = '0;

      // Reset while idle.
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset idle outputs", {rdata[27:0], ready, busy, misaligned, 1'b0}, 32'd0);
      reset = 1'b0;

      // A completed store that the later reset must wipe.
      v = '{"store w 0x14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h5555_5555, 32'h0, 1'b0};
      run_vec(v);

      // Reset in the middle of WAIT aborts a store to 0x10.
      we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h1111_1111; req = 1'b1;
      @(posedge clock);
      #1 req = 1'b0;
      check("busy before abort", 32'(busy), 32'd1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async reset outputs", {28'd0, ready, busy, misaligned, |rdata}, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;

      vecs = '{
         '{"load w 0x10 after abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0},
         '{"load w 0x14 cleared",     1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0000_0000, 1'b0},
         '{"store w 0x20",            1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
         '{"load w 0x20",             1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0},
         '{"store b 0x21",            1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF80, 32'hDEAD_BEEF, 1'b0},
         '{"load sb 0x21",            1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0},
         '{"load ub 0x21",            1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_0080, 1'b0},
         '{"load w 0x20 after sb",    1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEAD_80EF, 1'b0},
         '{"store h 0x22",            1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_1234, 32'hDEAD_80EF, 1'b0},
         '{"load sh 0x22",            1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_1234, 1'b0},
         '{"load w 0x20 after sh",    1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_80EF, 1'b0},
         '{"misaligned load w 0x22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h1234_80EF, 1'b1},
         '{"misaligned store h 0x23", 1'b1, 2'b01, 1'b0, 32'h23, 32'hFFFF_FFFF, 32'h1234_80EF, 1'b1},
         '{"load w 0x20 unmodified",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_80EF, 1'b0},
         '{"load sh 0x20",            1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF_80EF, 1'b0},
         '{"load uh 0x20",            1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_80EF, 1'b0},
         '{"load sb 0x23",            1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0012, 1'b0},
         '{"load size11 0x20",        1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h1234_80EF, 1'b0}
      };
      foreach (vecs[i]) run_vec(vecs[i]);

      // Wrap-around store at 0x400 followed back-to-back by a load at 0x000.
      we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h400; wdata = 32'hA5A5_A5A5;
      req = 1'b1;
      @(posedge clock);
      // Requests during WAIT must be ignored.
      #1 addr = 32'h0; wdata = 32'hFFFF_FFFF;
      check("b2b busy E0", 32'(busy), 32'd1);
      @(posedge clock);
      #1;
      check("b2b busy E1", 32'(busy), 32'd1);
      @(posedge clock);
      #1;
      check("b2b store ready", {30'd0, ready, misaligned}, 32'd2);
      we = 1'b0;
      @(posedge clock);
      #1 req = 1'b0;
      check("b2b no bubble", {30'd0, busy, ready}, 32'd2);
      @(posedge clock);
      @(posedge clock);
      #1;
      check("b2b load ready", 32'(ready), 32'd1);
      check("b2b wrap rdata", rdata, 32'hA5A5_A5A5);
      @(posedge clock);
      #1;
      check("b2b idle after", {30'd0, busy, ready}, 32'd0);

      // The ignored store must not have reached word 0.
      v = '{"load w 0x400 alias", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hA5A5_A5A5, 1'b0};
      run_vec(v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
